// File: rtl/quad_core_pkg.sv
// Shared definitions for the quad-core 12-bit matrix-multiply engine.
// Holds the problem dimensions, the per-core FSM state type and the operand
// generators. The A and B operands are not stored anywhere. They are computed
// from their indices when needed.
package quad_core_pkg;

  localparam int DW            = 12;   // data/result width
  localparam int AW            = 12;   // read-address width
  localparam int N_CORES       = 4;
  localparam int M_ROWS        = 16;   // rows of A and C
  localparam int K_DIM         = 16;   // inner dimension
  localparam int N_COLS        = 32;   // columns of B and C
  localparam int ROWS_PER_CORE = 4;
  localparam int ACC_W         = 28;   // unsigned MAC accumulator width
  localparam int BANK_DEPTH    = ROWS_PER_CORE * N_COLS;  // 128 entries per core
  localparam int MAP_DEPTH     = M_ROWS * N_COLS;         // 512 mapped addresses

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } core_state_e;

  // A[i][k] = i + k + 1
  function automatic logic [DW-1:0] a_val(input logic [DW-1:0] i,
                                          input logic [DW-1:0] k);
    return i + k + 12'd1;
  endfunction

  // B[k][j] = j + 1. The value is the same down each column. The k term is
  // masked to zero so that a_val and b_val take their indices the same way.
  function automatic logic [DW-1:0] b_val(input logic [DW-1:0] k,
                                          input logic [DW-1:0] j);
    return j + 12'd1 + (k & 12'd0);
  endfunction

endpackage

// File: rtl/quad_core_if.sv
// Read/status bus of the quad-core engine.
//   addr_tb           : result read address (row*32 + col); >= 512 is unmapped
//   result            : registered read data, 1-cycle latency
//   end_process1..4   : per-core done flags (core 0..3)
// The master modport is the side that drives the address. The slave modport is
// the engine.
interface quad_core_if;
  import quad_core_pkg::*;

  logic [AW-1:0] addr_tb;
  logic [DW-1:0] result;
  logic          end_process1;
  logic          end_process2;
  logic          end_process3;
  logic          end_process4;

  modport master (
    output addr_tb,
    input  result,
    input  end_process1,
    input  end_process2,
    input  end_process3,
    input  end_process4
  );

  modport slave (
    input  addr_tb,
    output result,
    output end_process1,
    output end_process2,
    output end_process3,
    output end_process4
  );

endinterface

// File: rtl/quad_core_proc_core.sv
// proc_core: one processing core of the quad-core engine. It computes rows
// CORE_ID*4 .. CORE_ID*4+3 of C = A x B, one element at a time.
// Each element takes 16 MAC cycles and then 1 WRITE cycle.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   we         : bank write enable, high during the WRITE state
//   waddr      : bank-local address {row_in_core[1:0], col[4:0]}
//   wdata      : value stored for the finished element
//   done       : registered, high once all 128 elements are written
// Build option: RESULT_SAT_EN clamps stored values to 4095. Without it, the
// stored value is the low 12 bits of the accumulator (modulo 4096).
module proc_core
  import quad_core_pkg::*;
#(
  parameter int CORE_ID = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          we,
  output logic [6:0]    waddr,
  output logic [DW-1:0] wdata,
  output logic          done
);

  core_state_e      state_r;
  logic [3:0]       k_r;
  logic [4:0]       col_r;
  logic [1:0]       row_r;
  logic [ACC_W-1:0] acc_r;
  logic             done_r;

  logic [DW-1:0]    row_g_s;
  logic [2*DW-1:0]  prod_s;
  logic             we_s;
  logic [6:0]       waddr_s;
  logic [DW-1:0]    wdata_s;

  // Converts the accumulator into the 12-bit value stored in the bank.
  function automatic logic [DW-1:0] store_val(input logic [ACC_W-1:0] acc);
`ifdef RESULT_SAT_EN
    if (acc > 28'd4095) begin
      return 12'd4095;
    end else begin
      return acc[DW-1:0];
    end
`else
    return acc[DW-1:0];
`endif
  endfunction

  assign row_g_s = DW'(CORE_ID * ROWS_PER_CORE) + {10'd0, row_r};
  assign prod_s  = a_val(row_g_s, {8'd0, k_r}) * b_val({8'd0, k_r}, {7'd0, col_r});

  // Element sequencer: IDLE -> MAC x16 -> WRITE -> next element or DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      k_r     <= 4'd0;
      col_r   <= 5'd0;
      row_r   <= 2'd0;
      acc_r   <= 28'd0;
      done_r  <= 1'b0;
    end else begin
      // The done flag follows the DONE state by one edge.
      done_r <= (state_r == DONE);
      case (state_r)
        IDLE: begin
          k_r     <= 4'd0;
          acc_r   <= 28'd0;
          state_r <= MAC;
        end
        MAC: begin
          acc_r <= acc_r + {4'd0, prod_s};
          k_r   <= k_r + 4'd1;          // wraps to 0 after k = 15
          if (k_r == 4'd15) begin
            state_r <= WRITE;
          end else begin
            state_r <= MAC;
          end
        end
        WRITE: begin
          acc_r <= 28'd0;
          if (col_r == 5'd31) begin
            col_r <= 5'd0;
            if (row_r == 2'd3) begin
              state_r <= DONE;
            end else begin
              row_r   <= row_r + 2'd1;
              state_r <= MAC;
            end
          end else begin
            col_r   <= col_r + 5'd1;
            state_r <= MAC;
          end
        end
        DONE: begin
          state_r <= DONE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Write port is decoded from registered state only
  always_comb begin
    we_s    = 1'b0;
    waddr_s = {row_r, col_r};
    wdata_s = store_val(acc_r);
    if (state_r == WRITE) begin
      we_s = 1'b1;
    end else begin
      we_s = 1'b0;
    end
  end

  assign we    = we_s;
  assign waddr = waddr_s;
  assign wdata = wdata_s;
  assign done  = done_r;

endmodule

// File: rtl/quad_core_top.sv
// quad_core_top: four-core 12-bit matrix-multiply engine (C = A x B, with A
// 16x16 and B 16x32).
// Core k writes rows 4k..4k+3 into its own 128x12 bank. Because the banks are
// separate, the cores never compete for a write port. The top owns the banks
// and the registered read mux.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : quad_core_if.slave. It carries addr_tb (in), result (out,
//           registered, 1-cycle latency, 0 for addresses >= 512) and
//           end_process1..4 (per-core done).
// Build option: RESULT_SAT_EN (see proc_core) selects saturating result storage.
// The banks have no reset. Read data is only meaningful after all done flags
// are high. A read of an address on the same edge it is written returns the
// old data.
module quad_core_top
  import quad_core_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  quad_core_if.slave  bus
);

  logic [N_CORES-1:0] we_s;
  logic [N_CORES-1:0] done_s;
  logic [6:0]         waddr_s [N_CORES];
  logic [DW-1:0]      wdata_s [N_CORES];
  logic [DW-1:0]      rd_s    [N_CORES];
  logic [DW-1:0]      result_r;

  for (genvar g = 0; g < N_CORES; g++) begin : g_core
    logic [DW-1:0] bank_r [BANK_DEPTH];

    proc_core #(.CORE_ID(g)) u_core (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we_s[g]),
      .waddr (waddr_s[g]),
      .wdata (wdata_s[g]),
      .done  (done_s[g])
    );

    // Result bank write port for this core (storage is not reset)
    always_ff @(posedge clk) begin
      if (we_s[g]) begin
        bank_r[waddr_s[g]] <= wdata_s[g];
      end
    end

    assign rd_s[g] = bank_r[bus.addr_tb[6:0]];
  end

  // Registered read mux. addr[8:7] selects the bank. Unmapped addresses read as 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= 12'd0;
    end else if (bus.addr_tb >= 12'(MAP_DEPTH)) begin
      result_r <= 12'd0;
    end else begin
      result_r <= rd_s[bus.addr_tb[8:7]];
    end
  end

  assign bus.result       = result_r;
  assign bus.end_process1 = done_s[0];
  assign bus.end_process2 = done_s[1];
  assign bus.end_process3 = done_s[2];
  assign bus.end_process4 = done_s[3];

endmodule

// File: tb/tb_quad_core_top.sv
// Self-checking bench for quad_core_top. It compares the DUT against a
// reference that evaluates C[i][j] = sum_k A[i][k]*B[k][j] directly from the
// operand rules.
module tb_quad_core_top;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  quad_core_if bus ();

  quad_core_top dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] flags;
  assign flags = {bus.end_process4, bus.end_process3, bus.end_process2, bus.end_process1};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: sum over the inner dimension, then apply the storage rule.
  function automatic int ref_c(input int addr);
    int row, col, sum;
    if (addr >= 512) return 0;
    row = addr / 32;
    col = addr % 32;
    sum = 0;
    for (int k = 0; k < 16; k++) sum += (row + k + 1) * (col + 1);
`ifdef RESULT_SAT_EN
    return (sum > 4095) ? 4095 : sum;
`else
    return sum % 4096;
`endif
  endfunction

  // Counts rising edges from the reset release until any flag rises.
  // The wait is bounded so that the bench always finishes.
  task automatic wait_done(output int first_edge, output logic [3:0] seen);
    first_edge = 0;
    seen       = 4'd0;
    for (int e = 1; e <= 3000; e++) begin
      @(posedge clk);
      #1;
      if (flags != 4'd0) begin
        first_edge = e;
        seen       = flags;
        break;
      end
    end
  endtask

  task automatic read_addr(input int a, output logic [11:0] d);
    @(negedge clk);
    bus.addr_tb = a[11:0];
    @(posedge clk);
    #1;
    d = bus.result;
  endtask

  task automatic check_directed(input string sfx);
    logic [11:0] d;
    read_addr(0, d);   check_eq({"rd0", sfx}, d, 32'd136);
    read_addr(1, d);   check_eq({"rd1", sfx}, d, 32'd272);
    read_addr(128, d); check_eq({"rd128", sfx}, d, 32'd200);
  endtask

  initial begin
    int          fe;
    logic [3:0]  sf;
    logic [11:0] d;
    int          a;

    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.addr_tb = 12'd0;

    // Scenario 1: outputs stay at zero while reset is held.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("rst_result", bus.result, 32'd0);
      check_eq("rst_flags", flags, 32'd0);
    end

    // Scenario 2: the flags rise together on edge 2178 after the release.
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(fe, sf);
    check_eq("rise_edge", fe, 32'd2178);
    check_eq("rise_all", sf, 32'hf);

    // Scenarios 3 to 5: directed reads, the unmapped address, the full sweep, then random reads.
    check_directed("");
    read_addr(127, d);
`ifdef RESULT_SAT_EN
    check_eq("rd127", d, 32'd4095);
`else
    check_eq("rd127", d, 32'd1792);
`endif
    read_addr(600, d);
    check_eq("rd600", d, 32'd0);
    for (int i = 0; i < 512; i++) begin
      read_addr(i, d);
      check_eq("sweep", d, ref_c(i));
    end
    for (int i = 0; i < 100; i++) begin
      a = int'($urandom_range(4095, 0));
      read_addr(a, d);
      check_eq("rand_rd", d, ref_c(a));
    end
    check_eq("flags_hold", flags, 32'hf);

    // Async reset after done: the flags and the result drop before any clock edge.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_flags", flags, 32'd0);
    check_eq("async_result", bus.result, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Scenario 6: pulse reset at cycle 1000 and check a full restart.
    repeat (1000) @(posedge clk);
    #2;
    check_eq("mid_flags", flags, 32'd0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(fe, sf);
    check_eq("rerise_edge", fe, 32'd2178);
    check_eq("rerise_all", sf, 32'hf);
    check_directed("_re");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
